// File: rtl/mme_seq_ctrl.sv
// +-----------------------------------------------------------------------------+
// | mme_seq_ctrl : MME sequencer - fetches A columns / B rows, steps the 4x4    |
// |                MAC array W times, writes C. Option: MME_PERF_CNT_EN.        |
// | Revision     : 1.0                                                          |
// +-----------------------------------------------------------------------------+
`default_nettype none

module mme_seq_ctrl #(
   parameter int ADDR_W    = 32,
   parameter int WIDTH_W   = 16,
   parameter int MAX_WIDTH = 256
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start_i,
   input  logic [WIDTH_W-1:0] mat_width_i,
   input  logic [ADDR_W-1:0]  mat_a_addr_i,
   input  logic [ADDR_W-1:0]  mat_b_addr_i,
   input  logic [ADDR_W-1:0]  mat_c_addr_i,
   output logic               busy_o,
   output logic               done_o,
   output logic               err_o,
   output logic               rd_req_o,
   output logic [ADDR_W-1:0]  rd_addr_o,
   output logic [3:0]         rd_len_o,
   input  logic               rd_ack_i,
   input  logic               rd_last_i,
   output logic               rd_sel_o,
   output logic               mac_clr_o,
   output logic               mac_en_o,
   output logic               wr_req_o,
   output logic [ADDR_W-1:0]  wr_addr_o,
   output logic [3:0]         wr_len_o,
   input  logic               wr_ack_i,
   input  logic               wr_done_i
`ifdef MME_PERF_CNT_EN
   ,
   output logic [31:0]        perf_cycles_o
`endif
);

   localparam logic [3:0] S_IDLE    = 4'd0;
   localparam logic [3:0] S_CLR     = 4'd1;
   localparam logic [3:0] S_RD_A    = 4'd2;
   localparam logic [3:0] S_WAIT_A  = 4'd3;
   localparam logic [3:0] S_RD_B    = 4'd4;
   localparam logic [3:0] S_WAIT_B  = 4'd5;
   localparam logic [3:0] S_MAC     = 4'd6;
   localparam logic [3:0] S_WR      = 4'd7;
   localparam logic [3:0] S_WAIT_WR = 4'd8;

   localparam logic [WIDTH_W-1:0] C_MAX_W    = WIDTH_W'(MAX_WIDTH);
   localparam logic [WIDTH_W-1:0] C_K_ONE    = WIDTH_W'(1);
   localparam logic [ADDR_W-1:0]  C_PTR_STEP = ADDR_W'(16);

   logic [3:0]         state_q, state_d;
   logic [WIDTH_W-1:0] w_q, k_q;
   logic [ADDR_W-1:0]  a_ptr_q, b_ptr_q, c_addr_q;
   logic               done_q, err_q;
   logic               cfg_bad;
   logic               start_ok;
   logic               last_step;

   // W must be a non-zero multiple of the 4-wide array and fit the operand range
   assign cfg_bad   = (mat_width_i == '0) || (mat_width_i[1:0] != 2'b00) ||
                      (mat_width_i > C_MAX_W);
   assign start_ok  = (state_q == S_IDLE) && start_i;
   assign last_step = ((k_q + C_K_ONE) == w_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:    if (start_i && !cfg_bad) state_d = S_CLR;
         S_CLR:     state_d = S_RD_A;
         S_RD_A:    if (rd_ack_i)  state_d = S_WAIT_A;
         S_WAIT_A:  if (rd_last_i) state_d = S_RD_B;
         S_RD_B:    if (rd_ack_i)  state_d = S_WAIT_B;
         S_WAIT_B:  if (rd_last_i) state_d = S_MAC;
         S_MAC:     state_d = last_step ? S_WR : S_RD_A;
         S_WR:      if (wr_ack_i)  state_d = S_WAIT_WR;
         S_WAIT_WR: if (wr_done_i) state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busy_o    = (state_q != S_IDLE);
      rd_req_o  = 1'b0;
      rd_addr_o = '0;
      rd_len_o  = 4'd0;
      rd_sel_o  = 1'b0;
      mac_clr_o = 1'b0;
      mac_en_o  = 1'b0;
      wr_req_o  = 1'b0;
      wr_addr_o = '0;
      wr_len_o  = 4'd0;
      case (state_q)
         S_CLR:  mac_clr_o = 1'b1;
         S_RD_A: begin
            rd_req_o  = 1'b1;
            rd_addr_o = a_ptr_q;
            rd_len_o  = 4'd3;
         end
         S_RD_B: begin
            rd_req_o  = 1'b1;
            rd_addr_o = b_ptr_q;
            rd_len_o  = 4'd3;
            rd_sel_o  = 1'b1;
         end
         S_MAC:  mac_en_o = 1'b1;
         S_WR: begin
            wr_req_o  = 1'b1;
            wr_addr_o = c_addr_q;
            wr_len_o  = 4'd15;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         w_q      <= '0;
         k_q      <= '0;
         a_ptr_q  <= '0;
         b_ptr_q  <= '0;
         c_addr_q <= '0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else if (start_ok) begin
         w_q      <= mat_width_i;
         k_q      <= '0;
         a_ptr_q  <= mat_a_addr_i;
         b_ptr_q  <= mat_b_addr_i;
         c_addr_q <= mat_c_addr_i;
         done_q   <= 1'b0;
         err_q    <= cfg_bad;
      end else if (state_q == S_MAC) begin
         k_q     <= k_q + C_K_ONE;
         a_ptr_q <= a_ptr_q + C_PTR_STEP;
         b_ptr_q <= b_ptr_q + C_PTR_STEP;
      end else if ((state_q == S_WAIT_WR) && wr_done_i) begin
         done_q <= 1'b1;
      end
   end

   assign done_o = done_q;
   assign err_o  = err_q;

`ifdef MME_PERF_CNT_EN
   logic [31:0] perf_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                    perf_q <= '0;
      else if (start_ok)             perf_q <= '0;
      else if (busy_o && perf_q != '1) perf_q <= perf_q + 32'd1;
   end

   assign perf_cycles_o = perf_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mme_seq_ctrl.sv
// +-----------------------------------------------------------------------------+
// | tb_mme_seq_ctrl : directed self-checking bench for mme_seq_ctrl with a      |
// |                   configurable-latency read/write responder.               |
// | Revision        : 1.0                                                      |
// +-----------------------------------------------------------------------------+
`default_nettype none

module tb_mme_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start_i;
   logic [15:0] mat_width_i;
   logic [31:0] mat_a_addr_i, mat_b_addr_i, mat_c_addr_i;
   logic        busy_o, done_o, err_o;
   logic        rd_req_o;
   logic [31:0] rd_addr_o;
   logic [3:0]  rd_len_o;
   logic        rd_ack_i, rd_last_i, rd_sel_o;
   logic        mac_clr_o, mac_en_o;
   logic        wr_req_o;
   logic [31:0] wr_addr_o;
   logic [3:0]  wr_len_o;
   logic        wr_ack_i, wr_done_i;
`ifdef MME_PERF_CNT_EN
   logic [31:0] perf_cycles_o;
`endif

   mme_seq_ctrl dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start_i      (start_i),
      .mat_width_i  (mat_width_i),
      .mat_a_addr_i (mat_a_addr_i),
      .mat_b_addr_i (mat_b_addr_i),
      .mat_c_addr_i (mat_c_addr_i),
      .busy_o       (busy_o),
      .done_o       (done_o),
      .err_o        (err_o),
      .rd_req_o     (rd_req_o),
      .rd_addr_o    (rd_addr_o),
      .rd_len_o     (rd_len_o),
      .rd_ack_i     (rd_ack_i),
      .rd_last_i    (rd_last_i),
      .rd_sel_o     (rd_sel_o),
      .mac_clr_o    (mac_clr_o),
      .mac_en_o     (mac_en_o),
      .wr_req_o     (wr_req_o),
      .wr_addr_o    (wr_addr_o),
      .wr_len_o     (wr_len_o),
      .wr_ack_i     (wr_ack_i),
      .wr_done_i    (wr_done_i)
`ifdef MME_PERF_CNT_EN
      ,
      .perf_cycles_o(perf_cycles_o)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Responder and monitor state, all updated on the falling edge
   int          ack_delay = 0;
   int          wait_cnt, rd_n, wr_n, busy_n, mac_en_n, mac_clr_n;
   int          stable_bad, len_bad, sel_bad;
   logic        last_pend, wdone_pend;
   logic [31:0] held_addr, wr_addr_l;
   logic [3:0]  wr_len_l;
   logic [31:0] rd_log [0:63];

   initial begin
      rd_ack_i = 0; rd_last_i = 0; wr_ack_i = 0; wr_done_i = 0;
      last_pend = 0; wdone_pend = 0; wait_cnt = 0;
      forever begin
         @(negedge clk);
         rd_ack_i = 0; rd_last_i = 0; wr_ack_i = 0; wr_done_i = 0;
         if (!rst_n) begin
            last_pend = 0; wdone_pend = 0; wait_cnt = 0;
         end else begin
            busy_n    += int'(busy_o);
            mac_en_n  += int'(mac_en_o);
            mac_clr_n += int'(mac_clr_o);
            rd_last_i  = last_pend;
            last_pend  = 0;
            wr_done_i  = wdone_pend;
            wdone_pend = 0;
            if (rd_req_o) begin
               if (wait_cnt == 0) held_addr = rd_addr_o;
               else if (rd_addr_o !== held_addr) stable_bad++;
               if (rd_len_o !== 4'd3) len_bad++;
               if (wait_cnt >= ack_delay) begin
                  rd_ack_i  = 1;
                  last_pend = 1;
                  wait_cnt  = 0;
                  if (rd_n < 64) rd_log[rd_n] = rd_addr_o;
                  if (rd_sel_o !== rd_n[0]) sel_bad++;
                  rd_n++;
               end else begin
                  wait_cnt++;
               end
            end
            if (wr_req_o) begin
               wr_ack_i   = 1;
               wdone_pend = 1;
               wr_addr_l  = wr_addr_o;
               wr_len_l   = wr_len_o;
               wr_n++;
            end
         end
      end
   end

   task automatic clear_stats();
      rd_n = 0; wr_n = 0; busy_n = 0; mac_en_n = 0; mac_clr_n = 0;
      stable_bad = 0; len_bad = 0; sel_bad = 0;
      wr_addr_l = '0; wr_len_l = '0;
   endtask

   // Drives a one-cycle start pulse; returns #1 after the sampling edge
   task automatic pulse_start(input logic [15:0] w, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] c);
      mat_width_i = w; mat_a_addr_i = a; mat_b_addr_i = b; mat_c_addr_i = c;
      start_i = 1;
      @(posedge clk); #1;
      start_i = 0;
   endtask

   task automatic wait_done(input int budget);
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (done_o) break;
      end
      check("done_wait", done_o, 1);
   endtask

   task automatic wait_rd_b(input int budget);
      for (int i = 0; i < budget; i++) begin
         @(posedge clk); #1;
         if (rd_req_o && rd_sel_o) break;
      end
      check("reach_rd_b", {rd_req_o, rd_sel_o}, 2'b11);
      @(posedge clk); #1;
   endtask

   logic [31:0] exp_rd [0:7];

   initial begin
      rst_n = 0; start_i = 0; mat_width_i = '0;
      mat_a_addr_i = '0; mat_b_addr_i = '0; mat_c_addr_i = '0;
      clear_stats();
      repeat (3) @(posedge clk);
      #1;
      check("reset_flags", {busy_o, done_o, err_o, rd_req_o, rd_sel_o,
                            mac_clr_o, mac_en_o, wr_req_o}, 8'h00);
      check("reset_addrs", {rd_addr_o, wr_addr_o}, 64'h0);
      check("reset_lens", {rd_len_o, wr_len_o}, 8'h00);
      rst_n = 1;
      @(posedge clk); #1;

      // W=4 zero-wait
      ack_delay = 0;
      clear_stats();
      pulse_start(16'd4, 32'h0, 32'h1000, 32'h2000);
      check("w4_busy_after_start", busy_o, 1);
      wait_done(200);
      exp_rd[0] = 32'h0;  exp_rd[1] = 32'h1000; exp_rd[2] = 32'h10; exp_rd[3] = 32'h1010;
      exp_rd[4] = 32'h20; exp_rd[5] = 32'h1020; exp_rd[6] = 32'h30; exp_rd[7] = 32'h1030;
      check("w4_rd_count", rd_n, 8);
      for (int i = 0; i < 8; i++) check($sformatf("w4_rd_addr%0d", i), rd_log[i], exp_rd[i]);
      check("w4_mac_clr", mac_clr_n, 1);
      check("w4_mac_en", mac_en_n, 4);
      check("w4_wr_count", wr_n, 1);
      check("w4_wr_addr", wr_addr_l, 32'h2000);
      check("w4_wr_len", wr_len_l, 4'd15);
      check("w4_busy_cycles", busy_n, 23);
      check("w4_busy_end", busy_o, 0);
      check("w4_sel", sel_bad, 0);
      check("w4_rd_len", len_bad, 0);
`ifdef MME_PERF_CNT_EN
      check("perf_at_done", perf_cycles_o, 23);
      repeat (10) @(posedge clk);
      #1;
      check("perf_hold", perf_cycles_o, 23);
`endif
      repeat (2) @(posedge clk);
      #1;
      check("w4_done_sticky", done_o, 1);

      // W=16 with delayed read acknowledge
      ack_delay = 3;
      clear_stats();
      pulse_start(16'd16, 32'h0, 32'h1000, 32'h2000);
      wait_done(2000);
      check("w16_mac_en", mac_en_n, 16);
      check("w16_rd_count", rd_n, 32);
      check("w16_last_a", rd_log[30], 32'hF0);
      check("w16_last_b", rd_log[31], 32'h10F0);
      check("w16_rd_stable", stable_bad, 0);
      check("w16_sel", sel_bad, 0);
      ack_delay = 0;

      // Illegal widths
      clear_stats();
      pulse_start(16'd6, 32'h0, 32'h1000, 32'h2000);
      check("w6_flags", {err_o, busy_o, done_o}, 3'b100);
      repeat (5) @(posedge clk);
      #1;
      check("w6_no_read", rd_n, 0);
      pulse_start(16'd0, 32'h0, 32'h1000, 32'h2000);
      check("w0_flags", {err_o, busy_o, done_o}, 3'b100);
      repeat (5) @(posedge clk);
      #1;
      check("w0_no_read", rd_n, 0);
      pulse_start(16'd260, 32'h0, 32'h1000, 32'h2000);
      check("w260_flags", {err_o, busy_o, done_o}, 3'b100);

      // Start during WAIT_B is ignored
      clear_stats();
      pulse_start(16'd4, 32'h0, 32'h1000, 32'h2000);
      check("restart_err_clr", err_o, 0);
      wait_rd_b(50);
      pulse_start(16'd8, 32'h500, 32'h600, 32'h3000);
      wait_done(200);
      check("ignored_wr_addr", wr_addr_l, 32'h2000);
      check("ignored_mac_en", mac_en_n, 4);
      check("ignored_busy", busy_n, 23);

      // Asynchronous reset during WAIT_B
      clear_stats();
      pulse_start(16'd4, 32'h0, 32'h1000, 32'h2000);
      wait_rd_b(50);
      rst_n = 0;
      #1;
      check("abort_flags", {busy_o, done_o, err_o, rd_req_o, rd_sel_o,
                            mac_clr_o, mac_en_o, wr_req_o}, 8'h00);
      check("abort_addrs", {rd_addr_o, wr_addr_o}, 64'h0);
      @(posedge clk); #1;
      rst_n = 1;
      repeat (3) @(posedge clk);
      #1;
      check("abort_no_write", wr_n, 0);
      check("abort_idle", busy_o, 0);
      clear_stats();
      pulse_start(16'd8, 32'h4000, 32'h5000, 32'h6000);
      wait_done(400);
      check("w8_mac_en", mac_en_n, 8);
      check("w8_busy_cycles", busy_n, 43);
      check("w8_wr_addr", wr_addr_l, 32'h6000);
      check("w8_last_b", rd_log[15], 32'h5070);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire
